// File: rtl/voxel_pkg.sv
// Types and constants shared by the voxel traversal units, the world loader
// and the world-RAM arbiter.
package voxel_pkg;

    localparam int WORLD_SIZE_DEFAULT = 65536;

    typedef enum logic [7:0] {
        BLK_AIR    = 8'h00,
        BLK_STONE  = 8'h01,
        BLK_DIRT   = 8'h02,
        BLK_GRASS  = 8'h03,
        BLK_WATER  = 8'h04,
        BLK_WOOD   = 8'h05,
        BLK_LEAVES = 8'h06
    } BlockType;

    typedef struct packed {
        logic [3:0] z;
        logic [5:0] y;
        logic [5:0] x;
    } BlockPos;

    typedef enum logic {
        LOADING = 1'b0,
        SERVING = 1'b1
    } arb_state_t;

    // One in-flight read slot; idx is wide enough for the largest requester count.
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rsp_tag_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voxel_ram_arbiter_if.sv
// Requester / loader side bus of the world-RAM arbiter.
interface voxel_ram_arbiter_if #(
    parameter int N_REQ = 4
);
    import voxel_pkg::*;

    logic     [N_REQ-1:0] req_valid;
    BlockPos  [N_REQ-1:0] req_addr;
    logic     [N_REQ-1:0] req_ready;
    logic     [N_REQ-1:0] rsp_valid;
    BlockType             rsp_data;
    logic                 wr_valid;
    BlockType             wr_data;
    logic                 wr_ready;

    modport master (
        output req_valid, req_addr, wr_valid, wr_data,
        input  req_ready, rsp_valid, rsp_data, wr_ready
    );

    modport slave (
        input  req_valid, req_addr, wr_valid, wr_data,
        output req_ready, rsp_valid, rsp_data, wr_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. The caller owns and updates the pointer.
module rr_arbiter
    import voxel_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic found_s;
    int   j_s;

    // Scan N positions starting from ptr and take the first request seen
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        j_s       = 0;
        for (int k = 0; k < N; k++) begin
            j_s = (int'(ptr) + k) % N;
            if (enable && !found_s && req[j_s]) begin
                grant[j_s] = 1'b1;
                grant_idx  = IW'(j_s);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/voxel_ram_arbiter.sv
// Shares the world BRAM between the UART loader and N_REQ traversal readers.
// Optional per-requester stall counters are built when VOXEL_ARB_STATS_EN is defined.
module voxel_ram_arbiter
    import voxel_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int RAM_LATENCY = 2,
    parameter int WORLD_SIZE  = WORLD_SIZE_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    voxel_ram_arbiter_if.slave     bus,
    output logic                   initialized,
    output logic                   ram_en,
    output logic                   ram_we,
    output BlockPos                ram_addr,
    output BlockType               ram_wdata,
    input  BlockType               ram_rdata,
    output logic [N_REQ-1:0][31:0] stall_cnt
);

    localparam int      IDXW     = idx_width(N_REQ);
    localparam BlockPos LAST_POS = BlockPos'(16'(WORLD_SIZE - 1));

    arb_state_t       state_r;
    BlockPos          wr_ptr_r;
    logic [IDXW-1:0]  rr_ptr_r;
    logic             initialized_r;
    logic             wr_ready_r;
    logic             wr_fire_s;
    logic             rd_fire_s;
    logic             arb_en_s;
    logic [N_REQ-1:0] grant_s;
    logic [IDXW-1:0]  grant_idx_s;
    rsp_tag_t         tag_in_s;
    rsp_tag_t         tag_out_s;
    rsp_tag_t         tag_pipe_r [RAM_LATENCY];

    // wr_ready is held low only while reset is applied
    assign wr_fire_s = bus.wr_valid && wr_ready_r;
    assign arb_en_s  = (state_r == SERVING) && !wr_fire_s;
    assign rd_fire_s = |grant_s;

    rr_arbiter #(.N(N_REQ), .IW(IDXW)) u_rr (
        .req       (bus.req_valid),
        .enable    (arb_en_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign bus.req_ready = grant_s;
    assign bus.wr_ready  = wr_ready_r;
    assign initialized   = initialized_r;

    // BRAM port mux: the loader write wins over any read in the same cycle
    always_comb begin
        ram_en = wr_fire_s | rd_fire_s;
        ram_we = wr_fire_s;
        if (wr_fire_s) begin
            ram_addr  = wr_ptr_r;
            ram_wdata = bus.wr_data;
        end else if (rd_fire_s) begin
            ram_addr  = bus.req_addr[grant_idx_s];
            ram_wdata = BLK_AIR;
        end else begin
            ram_addr  = '0;
            ram_wdata = BLK_AIR;
        end
    end

    // Load/serve FSM with write pointer and round-robin pointer
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r       <= LOADING;
            wr_ptr_r      <= '0;
            rr_ptr_r      <= '0;
            initialized_r <= 1'b0;
            wr_ready_r    <= 1'b0;
        end else begin
            wr_ready_r <= 1'b1;
            if (wr_fire_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_POS) ? BlockPos'(16'd0)
                                                   : BlockPos'(wr_ptr_r + 16'd1);
            end
            case (state_r)
                LOADING: begin
                    if (wr_fire_s && (wr_ptr_r == LAST_POS)) begin
                        state_r       <= SERVING;
                        initialized_r <= 1'b1;
                    end
                end
                SERVING: begin
                    state_r       <= SERVING;
                    initialized_r <= 1'b1;
                end
                default: begin
                    state_r       <= LOADING;
                    initialized_r <= 1'b0;
                end
            endcase
            if (rd_fire_s) begin
                rr_ptr_r <= (grant_idx_s == IDXW'(N_REQ - 1)) ? '0
                                                              : grant_idx_s + IDXW'(1);
            end
        end
    end

    assign tag_in_s.valid = rd_fire_s;
    assign tag_in_s.idx   = 3'(grant_idx_s);

    // Requester tag follows the BRAM read latency; write slots travel as invalid
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                tag_pipe_r[k] <= '0;
            end
        end else begin
            tag_pipe_r[0] <= tag_in_s;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                tag_pipe_r[k] <= tag_pipe_r[k-1];
            end
        end
    end

    assign tag_out_s = tag_pipe_r[RAM_LATENCY-1];

    // Route the returning BRAM data to its requester; bus idles at zero
    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.rsp_valid[i] = tag_out_s.valid && (tag_out_s.idx == 3'(i));
        end
        if (tag_out_s.valid) begin
            bus.rsp_data = ram_rdata;
        end else begin
            bus.rsp_data = BLK_AIR;
        end
    end

`ifdef VOXEL_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] stall_cnt_r;

    // Saturating count of cycles each requester waited with a pending request
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stall_cnt_r <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && !grant_s[i] && (stall_cnt_r[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt_r[i] <= stall_cnt_r[i] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = '0;
`endif

endmodule
